// File: rtl/sap1_pkg.sv
// sap1_pkg -- definitions shared by the SAP-1 style datapath blocks.
//
// Contents:
//   DATA_W        datapath width (8)
//   opcode_e      4-bit instruction opcodes seen by the control sequencer
//   alu_op_e      decoded ALU operation handed to alu_core
//   alu_op_select priority encoder: sub_add > cmp > xor > and > or > ADD
//   multi_select  high when more than one raw op select is asserted
package sap1_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        OPC_LDA = 4'h0,
        OPC_ADD = 4'h1,
        OPC_SUB = 4'h2,
        OPC_AND = 4'h3,
        OPC_OR  = 4'h4,
        OPC_XOR = 4'h5,
        OPC_CMP = 4'h6,
        OPC_OUT = 4'hE,
        OPC_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_OR  = 3'd1,
        ALU_AND = 3'd2,
        ALU_XOR = 3'd3,
        ALU_CMP = 3'd4,
        ALU_SUB = 3'd5
    } alu_op_e;

    // With no select asserted the ALU defaults to ADD.
    function automatic alu_op_e alu_op_select(input logic sub_sel,
                                              input logic cmp_sel,
                                              input logic xor_sel,
                                              input logic and_sel,
                                              input logic or_sel);
        alu_op_e op;
        if (sub_sel)      op = ALU_SUB;
        else if (cmp_sel) op = ALU_CMP;
        else if (xor_sel) op = ALU_XOR;
        else if (and_sel) op = ALU_AND;
        else if (or_sel)  op = ALU_OR;
        else              op = ALU_ADD;
        return op;
    endfunction

    function automatic logic multi_select(input logic sub_sel,
                                          input logic cmp_sel,
                                          input logic xor_sel,
                                          input logic and_sel,
                                          input logic or_sel);
        logic [2:0] cnt;
        cnt = {2'b00, sub_sel} + {2'b00, cmp_sel} + {2'b00, xor_sel}
            + {2'b00, and_sel} + {2'b00, or_sel};
        return (cnt > 3'd1);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core -- purely combinational ALU.
//
// Ports:
//   a      in  DATA_W  first operand (accumulator)
//   b      in  DATA_W  second operand (B register)
//   op     in  alu_op_e decoded operation
//   result out DATA_W  operation result, wraps modulo 2^DATA_W
//   carry  out 1       ADD: carry out; SUB/CMP: 1 = no borrow (a >= b);
//                      logic ops: 0
module alu_core
    import sap1_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            // Two's-complement subtract; the carry out is the inverted borrow.
            ALU_SUB, ALU_CMP: begin
                sum    = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_datapath.sv
// alu_datapath -- accumulator, B register, flags and ALU bus driver.
//
// Ports:
//   clk, clr               clock; asynchronous active-low reset
//   bus_in                 W-bus value, source for accumulator and B loads
//   low_ld_acc/low_ld_b_reg active-low load strobes
//   acc_out_en             drive accumulator onto the bus (wins contention)
//   subadd_out_en          drive ALU result onto the bus; ALU commit cycle
//   sub_add..cmp_ratna     raw ALU op selects (priority-encoded in sap1_pkg)
//   bus_out, bus_drive     value driven and its qualifier
//   acc_q, b_q             register contents
//   flag_z/c/n             flags, updated only on a commit that also loads acc
//   seq_err                sticky protocol error
//
// Bus protocol: bus_drive is the only qualifier of bus_out; whenever it is
// low bus_out is 0x00 and must be ignored. There is no back-pressure.
module alu_datapath
    import sap1_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              low_ld_acc,
    input  logic              low_ld_b_reg,
    input  logic              acc_out_en,
    input  logic              subadd_out_en,
    input  logic              sub_add,
    input  logic              xor_ratna,
    input  logic              and_ratna,
    input  logic              or_ratna,
    input  logic              cmp_ratna,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic [DATA_W-1:0] acc_q,
    output logic [DATA_W-1:0] b_q,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n,
    output logic              seq_err
);

    alu_op_e           op_sel;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] b_d;
    logic              flag_z_d;
    logic              flag_c_d;
    logic              flag_n_d;
    logic              seq_err_d;

    logic acc_ld;
    logic flag_ld;
    logic err_set;

    assign op_sel = alu_op_select(sub_add, cmp_ratna, xor_ratna, and_ratna, or_ratna);

    alu_core u_alu_core (
        .a      (acc_q),
        .b      (b_q),
        .op     (op_sel),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // A compare commit only updates flags; the accumulator keeps its value
    // even though the sequencer asserts the load strobe.
    assign acc_ld  = ~low_ld_acc & ~(subadd_out_en & (op_sel == ALU_CMP));
    assign flag_ld = subadd_out_en & ~low_ld_acc;
    assign err_set = (acc_out_en & subadd_out_en)
                   | (subadd_out_en & multi_select(sub_add, cmp_ratna, xor_ratna,
                                                   and_ratna, or_ratna));

    always_comb begin
        acc_d     = acc_q;
        b_d       = b_q;
        flag_z_d  = flag_z;
        flag_c_d  = flag_c;
        flag_n_d  = flag_n;
        seq_err_d = seq_err | err_set;
        if (acc_ld)
            acc_d = bus_in;
        if (!low_ld_b_reg)
            b_d = bus_in;
        if (flag_ld) begin
            flag_z_d = (alu_result == '0);
            flag_c_d = alu_carry;
            flag_n_d = alu_result[DATA_W-1];
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc_q   <= '0;
            b_q     <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_n  <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            b_q     <= b_d;
            flag_z  <= flag_z_d;
            flag_c  <= flag_c_d;
            flag_n  <= flag_n_d;
            seq_err <= seq_err_d;
        end
    end

    always_comb begin
        bus_out = '0;
        if (acc_out_en)
            bus_out = acc_q;
        else if (subadd_out_en)
            bus_out = alu_result;
    end

    assign bus_drive = acc_out_en | subadd_out_en;

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath -- self-checking bench for alu_datapath.
// The W-bus is modelled as: the DUT's bus_out when it drives, otherwise the
// bench's own value, so ALU commits write back through bus_in.
module tb_alu_datapath;

    localparam int T_ADD = 0;
    localparam int T_SUB = 1;
    localparam int T_CMP = 2;
    localparam int T_AND = 3;
    localparam int T_OR  = 4;
    localparam int T_XOR = 5;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         op;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       n;
        logic [7:0] acc_after;
    } vec_t;

    logic       clk;
    logic       clr;
    logic [7:0] bus_in;
    logic [7:0] drv_bus;
    logic       low_ld_acc;
    logic       low_ld_b_reg;
    logic       acc_out_en;
    logic       subadd_out_en;
    logic       sub_add;
    logic       xor_ratna;
    logic       and_ratna;
    logic       or_ratna;
    logic       cmp_ratna;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic [7:0] acc_q;
    logic [7:0] b_q;
    logic       flag_z;
    logic       flag_c;
    logic       flag_n;
    logic       seq_err;

    int n_cmp;
    int n_fail;

    vec_t vecs[8];

    // reference model state
    logic [7:0] m_acc;
    logic [7:0] m_b;
    logic       m_z;
    logic       m_c;
    logic       m_n;

    assign bus_in = bus_drive ? bus_out : drv_bus;

    alu_datapath dut (
        .clk           (clk),
        .clr           (clr),
        .bus_in        (bus_in),
        .low_ld_acc    (low_ld_acc),
        .low_ld_b_reg  (low_ld_b_reg),
        .acc_out_en    (acc_out_en),
        .subadd_out_en (subadd_out_en),
        .sub_add       (sub_add),
        .xor_ratna     (xor_ratna),
        .and_ratna     (and_ratna),
        .or_ratna      (or_ratna),
        .cmp_ratna     (cmp_ratna),
        .bus_out       (bus_out),
        .bus_drive     (bus_drive),
        .acc_q         (acc_q),
        .b_q           (b_q),
        .flag_z        (flag_z),
        .flag_c        (flag_c),
        .flag_n        (flag_n),
        .seq_err       (seq_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        low_ld_acc    = 1'b1;
        low_ld_b_reg  = 1'b1;
        acc_out_en    = 1'b0;
        subadd_out_en = 1'b0;
        sub_add       = 1'b0;
        xor_ratna     = 1'b0;
        and_ratna     = 1'b0;
        or_ratna      = 1'b0;
        cmp_ratna     = 1'b0;
    endtask

    task automatic set_op(input int op);
        sub_add   = (op == T_SUB);
        cmp_ratna = (op == T_CMP);
        and_ratna = (op == T_AND);
        or_ratna  = (op == T_OR);
        xor_ratna = (op == T_XOR);
    endtask

    // driver: load acc and/or B from the bench's bus value
    task automatic load(input logic ld_a, input logic ld_b, input logic [7:0] val);
        @(negedge clk);
        set_idle();
        drv_bus      = val;
        low_ld_acc   = ~ld_a;
        low_ld_b_reg = ~ld_b;
        @(posedge clk);
        #1;
    endtask

    // driver: ALU commit; bus_out is checked in the same cycle
    task automatic commit(input string name, input int op, input logic ld_a,
                          input logic [7:0] exp_bus);
        @(negedge clk);
        set_idle();
        set_op(op);
        subadd_out_en = 1'b1;
        low_ld_acc    = ~ld_a;
        #1;
        chk({name, ".bus_out"}, bus_out, exp_bus);
        chk({name, ".bus_drive"}, {7'd0, bus_drive}, 8'd1);
        @(posedge clk);
        #1;
    endtask

    // reference ALU from the arithmetic rules, not bit tricks
    task automatic ref_alu(input int op, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] res, output logic c);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        res = 8'h00;
        c   = 1'b0;
        case (op)
            T_ADD: begin
                res = 8'((ia + ib) % 256);
                c   = (ia + ib) > 255;
            end
            T_SUB, T_CMP: begin
                res = 8'((ia - ib + 256) % 256);
                c   = ia >= ib;
            end
            T_AND: res = a & b;
            T_OR:  res = a | b;
            T_XOR: res = a ^ b;
            default: res = 8'h00;
        endcase
    endtask

    initial begin
        logic [7:0] r;
        logic       rc;
        n_cmp   = 0;
        n_fail  = 0;
        drv_bus = 8'h00;
        set_idle();

        vecs[0] = '{8'h05, 8'h03, T_ADD, 8'h08, 1'b0, 1'b0, 1'b0, 8'h08};
        vecs[1] = '{8'hFF, 8'h01, T_ADD, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{8'h03, 8'h05, T_SUB, 8'hFE, 1'b0, 1'b0, 1'b1, 8'hFE};
        vecs[3] = '{8'h42, 8'h42, T_CMP, 8'h00, 1'b1, 1'b1, 1'b0, 8'h42};
        vecs[4] = '{8'hF0, 8'h3C, T_AND, 8'h30, 1'b0, 1'b0, 1'b0, 8'h30};
        vecs[5] = '{8'hF0, 8'h3C, T_XOR, 8'hCC, 1'b0, 1'b0, 1'b1, 8'hCC};
        vecs[6] = '{8'hF0, 8'h3C, T_OR,  8'hFC, 1'b0, 1'b0, 1'b1, 8'hFC};
        vecs[7] = '{8'h10, 8'h20, T_CMP, 8'hF0, 1'b0, 1'b0, 1'b1, 8'h10};

        // reset: load strobe and bus value present but ignored
        clr        = 1'b0;
        drv_bus    = 8'hAA;
        low_ld_acc = 1'b0;
        acc_out_en = 1'b1;
        #1;
        chk("rst.acc_async", acc_q, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rst.acc", acc_q, 8'h00);
        chk("rst.b", b_q, 8'h00);
        chk("rst.flags", {5'd0, flag_z, flag_c, flag_n}, 8'h00);
        chk("rst.seq_err", {7'd0, seq_err}, 8'h00);
        chk("rst.bus_out", bus_out, 8'h00);
        chk("rst.bus_drive", {7'd0, bus_drive}, 8'd1);
        @(negedge clk);
        acc_out_en = 1'b0;
        clr        = 1'b1;
        #1;
        chk("rel.no_load_yet", acc_q, 8'h00);
        @(posedge clk);
        #1;
        chk("rel.first_load", acc_q, 8'hAA);
        chk("idle.bus_drive", {7'd0, bus_drive}, 8'd0);
        chk("idle.bus_out", bus_out, 8'h00);

        // table-driven directed vectors
        for (int i = 0; i < 8; i++) begin
            load(1'b1, 1'b0, vecs[i].a);
            load(1'b0, 1'b1, vecs[i].b);
            commit($sformatf("vec%0d", i), vecs[i].op, 1'b1, vecs[i].res);
            chk($sformatf("vec%0d.acc", i), acc_q, vecs[i].acc_after);
            chk($sformatf("vec%0d.z", i), {7'd0, flag_z}, {7'd0, vecs[i].z});
            chk($sformatf("vec%0d.c", i), {7'd0, flag_c}, {7'd0, vecs[i].c});
            chk($sformatf("vec%0d.n", i), {7'd0, flag_n}, {7'd0, vecs[i].n});
        end

        // randomized stimulus against the reference model
        m_acc = vecs[7].acc_after;
        m_b   = vecs[7].b;
        m_z   = vecs[7].z;
        m_c   = vecs[7].c;
        m_n   = vecs[7].n;
        for (int i = 0; i < 60; i++) begin
            int         mode;
            int         op;
            logic       ld;
            logic [7:0] v;
            mode = int'($urandom_range(0, 3));
            op   = int'($urandom_range(0, 5));
            ld   = ($urandom_range(0, 4) != 0);
            v    = 8'($urandom_range(0, 255));
            if (mode == 0) begin
                load(1'b1, 1'b0, v);
                m_acc = v;
            end else if (mode == 1) begin
                load(1'b0, 1'b1, v);
                m_b = v;
            end else if (mode == 2) begin
                load(1'b1, 1'b1, v);
                m_acc = v;
                m_b   = v;
            end
            ref_alu(op, m_acc, m_b, r, rc);
            commit($sformatf("rnd%0d", i), op, ld, r);
            if (ld) begin
                m_z = (r == 8'h00);
                m_c = rc;
                m_n = r[7];
                if (op != T_CMP)
                    m_acc = r;
            end
            chk($sformatf("rnd%0d.acc", i), acc_q, m_acc);
            chk($sformatf("rnd%0d.b", i), b_q, m_b);
            chk($sformatf("rnd%0d.flags", i), {5'd0, flag_z, flag_c, flag_n},
                {5'd0, m_z, m_c, m_n});
        end
        chk("rnd.seq_err", {7'd0, seq_err}, 8'h00);

        // flags hold across LDA and across a commit without acc load
        load(1'b1, 1'b0, 8'h77);
        chk("lda.acc", acc_q, 8'h77);
        chk("lda.flags_hold", {5'd0, flag_z, flag_c, flag_n}, {5'd0, m_z, m_c, m_n});
        load(1'b0, 1'b1, 8'h01);
        commit("nold", T_ADD, 1'b0, 8'h78);
        chk("nold.acc_hold", acc_q, 8'h77);
        chk("nold.flags_hold", {5'd0, flag_z, flag_c, flag_n}, {5'd0, m_z, m_c, m_n});

        // OUT instruction
        @(negedge clk);
        set_idle();
        acc_out_en = 1'b1;
        #1;
        chk("out.bus_out", bus_out, 8'h77);
        chk("out.bus_drive", {7'd0, bus_drive}, 8'd1);
        @(posedge clk);
        #1;
        chk("out.seq_err", {7'd0, seq_err}, 8'h00);

        // contention: acc wins, error is sticky until reset
        load(1'b1, 1'b0, 8'h5A);
        load(1'b0, 1'b1, 8'h11);
        @(negedge clk);
        set_idle();
        acc_out_en    = 1'b1;
        subadd_out_en = 1'b1;
        #1;
        chk("cont.bus_out", bus_out, 8'h5A);
        chk("cont.seq_err_pre", {7'd0, seq_err}, 8'h00);
        @(posedge clk);
        #1;
        chk("cont.seq_err", {7'd0, seq_err}, 8'h01);
        chk("cont.acc", acc_q, 8'h5A);
        load(1'b0, 1'b0, 8'h00);
        load(1'b0, 1'b0, 8'h00);
        chk("cont.sticky", {7'd0, seq_err}, 8'h01);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("cont.rst_seq_err", {7'd0, seq_err}, 8'h00);
        chk("cont.rst_acc", acc_q, 8'h00);
        @(negedge clk);
        clr = 1'b1;

        // multiple op selects: SUB has priority, error flagged
        load(1'b1, 1'b0, 8'h20);
        load(1'b0, 1'b1, 8'h05);
        @(negedge clk);
        set_idle();
        sub_add       = 1'b1;
        and_ratna     = 1'b1;
        subadd_out_en = 1'b1;
        low_ld_acc    = 1'b0;
        #1;
        chk("multi.bus_out", bus_out, 8'h1B);
        @(posedge clk);
        #1;
        chk("multi.acc", acc_q, 8'h1B);
        chk("multi.c", {7'd0, flag_c}, 8'd1);
        chk("multi.seq_err", {7'd0, seq_err}, 8'h01);

        @(negedge clk);
        set_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 clr  in  1  asynchronous, active-low reset.
REQ-003 bus_in  in  8  current W-bus value; source for accumulator and B loads.
REQ-004 low_ld_acc  in  1  active-low accumulator load strobe from control sequencer.
REQ-005 low_ld_b_reg  in  1  active-low B-register load strobe.
REQ-006 acc_out_en  in  1  drive accumulator onto bus (OUT instruction).
REQ-007 subadd_out_en  in  1  drive ALU result onto bus; marks the ALU commit cycle.
REQ-008 sub_add, xor_ratna, and_ratna, or_ratna, cmp_ratna  in  1 each  ALU operation selects; none high means ADD.
REQ-009 bus_out  out  8  value this block drives onto the bus.
REQ-010 bus_drive  out  1  high when bus_out is valid (acc_out_en | subadd_out_en).
REQ-011 acc_q  out  8  accumulator contents.
REQ-012 b_q  out  8  B-register contents.
REQ-013 flag_z, flag_c, flag_n  out  1 each  registered zero, carry/no-borrow and negative flags.
REQ-014 seq_err  out  1  sticky protocol-error indicator.

Function
REQ-015 ALU result SHALL be combinational from acc_q and b_q, selected by priority sub_add > cmp_ratna > xor_ratna > and_ratna > or_ratna > ADD.
REQ-016 ADD: 9-bit acc+b, result = bits[7:0], carry = bit 8.
REQ-017 SUB and CMP: acc + ~b + 1 in 9 bits; result = bits[7:0]; carry = bit 8 (1 means acc >= b, no borrow).
REQ-018 AND/OR/XOR: bitwise on 8 bits; carry SHALL be 0.
REQ-019 bus_out SHALL be acc_q when acc_out_en=1, else the ALU result when subadd_out_en=1, else 0x00.
REQ-020 Accumulator SHALL load bus_in on a rising edge when low_ld_acc=0, except when subadd_out_en=1 and cmp_ratna is the selected op (CMP never changes acc).
REQ-021 B register SHALL load bus_in on a rising edge when low_ld_b_reg=0; simultaneous acc and B load SHALL both take the same bus_in.
REQ-022 Flags SHALL update only on a rising edge with subadd_out_en=1 and low_ld_acc=0: Z = (result==0), N = result[7], C per REQ-016..018; flags hold otherwise, including across LDA.
REQ-023 Latency: ALU result visible on bus_out in the same cycle as subadd_out_en; acc_q and flags reflect it after that cycle's rising edge.
REQ-024 seq_err SHALL set on a rising edge when acc_out_en & subadd_out_en, or when more than one op select is high while subadd_out_en=1; it clears only on reset.
REQ-025 On contention (REQ-024), bus_out SHALL follow REQ-019 priority (acc wins) and all other behaviour is unchanged.
REQ-026 Accumulator arithmetic SHALL wrap modulo 256 with no saturation.

Reset
REQ-027 While clr=0: acc_q=0x00, b_q=0x00, flag_z=flag_c=flag_n=0, seq_err=0, immediately and regardless of clk.
REQ-028 Load strobes active during reset SHALL be ignored; the first load occurs on the first rising edge after clr returns high.
REQ-029 bus_out/bus_drive remain combinational and follow REQ-019 during reset (acc_q=0).

Structure
REQ-030 Op-select priority encoding and width constant (8) SHALL reside in the shared sap1 package alongside the instruction opcodes.
REQ-031 Combinational ALU SHALL be one sub-module, alu_core (inputs a, b, op; outputs result, carry); registers, flags and seq_err stay in alu_datapath.

Verification
REQ-032 Reset: clr=0 with low_ld_acc=0, bus_in=0xAA -> acc_q=0x00, flags 0, seq_err 0; after release no load until next edge.
REQ-033 Load acc 0x05, load B 0x03, ADD commit -> bus_out=0x08 same cycle, acc_q=0x08, Z=0 C=0 N=0.
REQ-034 acc 0xFF, B 0x01, ADD -> acc 0x00, Z=1 C=1; acc 0x03, B 0x05, SUB -> acc 0xFE, N=1 C=0.
REQ-035 acc 0x42, B 0x42, CMP with low_ld_acc=0 -> acc_q stays 0x42, Z=1 C=1 N=0.
REQ-036 acc 0xF0, B 0x3C: AND -> 0x30 C=0; XOR (from fresh 0xF0) -> 0xCC N=1; OR -> 0xFC.
REQ-037 acc_out_en=1 and subadd_out_en=1 together -> bus_out=acc_q, seq_err=1 after edge and stays 1 until clr=0.
